// File: rtl/display_timing_pkg.sv
// Shared timing constants and strobe bundle for the display scanout path.
package display_timing_pkg;

  localparam int DEFAULT_H_ACTIVE      = 640;
  localparam int DEFAULT_H_FRONT_PORCH = 16;
  localparam int DEFAULT_H_SYNC        = 32;
  localparam int DEFAULT_H_BACK_PORCH  = 48;
  localparam int DEFAULT_V_ACTIVE      = 400;
  localparam int DEFAULT_V_FRONT_PORCH = 4;
  localparam int DEFAULT_V_SYNC        = 2;
  localparam int DEFAULT_V_BACK_PORCH  = 10;
  localparam int DEFAULT_READ_LATENCY  = 2;

  localparam int H_TOTAL = DEFAULT_H_ACTIVE + DEFAULT_H_FRONT_PORCH
                         + DEFAULT_H_SYNC + DEFAULT_H_BACK_PORCH;
  localparam int V_TOTAL = DEFAULT_V_ACTIVE + DEFAULT_V_FRONT_PORCH
                         + DEFAULT_V_SYNC + DEFAULT_V_BACK_PORCH;

  localparam int PIXEL_ADDRESS_WIDTH = 18;
  localparam int PIXEL_WIDTH         = 4;
  localparam int FRAME_PIXELS        = DEFAULT_H_ACTIVE * DEFAULT_V_ACTIVE;

  // Raw per-cycle raster strobes, carried together through the latency delay line.
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
    logic frame_start;
  } raster_strobe_t;

endpackage

// File: rtl/display_timing_generator.sv
// Horizontal/vertical raster counters and the raw (undelayed) timing strobes.
module display_timing_generator
  import display_timing_pkg::*;
#(
  parameter int H_ACTIVE      = DEFAULT_H_ACTIVE,
  parameter int H_FRONT_PORCH = DEFAULT_H_FRONT_PORCH,
  parameter int H_SYNC        = DEFAULT_H_SYNC,
  parameter int H_BACK_PORCH  = DEFAULT_H_BACK_PORCH,
  parameter int V_ACTIVE      = DEFAULT_V_ACTIVE,
  parameter int V_FRONT_PORCH = DEFAULT_V_FRONT_PORCH,
  parameter int V_SYNC        = DEFAULT_V_SYNC,
  parameter int V_BACK_PORCH  = DEFAULT_V_BACK_PORCH
) (
  input  logic clock_in,
  input  logic reset_n,
  input  logic enable,
  output logic active,
  output logic hsync,
  output logic vsync,
  output logic frame_start
);

  localparam int LINE_TOTAL  = H_ACTIVE + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
  localparam int FRAME_TOTAL = V_ACTIVE + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
  localparam int HW = $clog2(LINE_TOTAL);
  localparam int VW = $clog2(FRAME_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(LINE_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FRONT_PORCH);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FRONT_PORCH + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(FRAME_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FRONT_PORCH);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FRONT_PORCH + V_SYNC);

  logic [HW-1:0] h_count;
  logic [VW-1:0] v_count;

  // Raster position; disable parks it at the top-left so the next run starts a fresh frame.
  always_ff @(posedge clock_in) begin
    if (!reset_n || !enable) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_count == H_LAST) begin
      h_count <= '0;
      v_count <= (v_count == V_LAST) ? '0 : v_count + VW'(1);
    end else begin
      h_count <= h_count + HW'(1);
    end
  end

  // Decode the raw strobes for the current raster position.
  always_comb begin
    active      = (h_count < H_ACT) && (v_count < V_ACT);
    hsync       = (h_count >= HS_START) && (h_count < HS_END);
    vsync       = (v_count >= VS_START) && (v_count < VS_END);
    frame_start = (h_count == '0) && (v_count == '0);
  end

endmodule

// File: rtl/display_scanout.sv
// Display buffer read master: raster address walk plus latency-aligned sync/pixel outputs.
module display_scanout
  import display_timing_pkg::*;
#(
  parameter int H_ACTIVE      = DEFAULT_H_ACTIVE,
  parameter int H_FRONT_PORCH = DEFAULT_H_FRONT_PORCH,
  parameter int H_SYNC        = DEFAULT_H_SYNC,
  parameter int H_BACK_PORCH  = DEFAULT_H_BACK_PORCH,
  parameter int V_ACTIVE      = DEFAULT_V_ACTIVE,
  parameter int V_FRONT_PORCH = DEFAULT_V_FRONT_PORCH,
  parameter int V_SYNC        = DEFAULT_V_SYNC,
  parameter int V_BACK_PORCH  = DEFAULT_V_BACK_PORCH,
  parameter int READ_LATENCY  = DEFAULT_READ_LATENCY   // must be >= 1
) (
  input  logic                           clock_in,
  input  logic                           reset_n_in,
  input  logic                           enable_in,
  output logic [PIXEL_ADDRESS_WIDTH-1:0] pixel_read_address_out,
  input  logic [PIXEL_WIDTH-1:0]         pixel_read_data_in,
  output logic                           display_hsync_out,
  output logic                           display_vsync_out,
  output logic                           display_data_valid_out,
  output logic [PIXEL_WIDTH-1:0]         display_pixel_out,
  output logic                           frame_start_out
);

  localparam logic [PIXEL_ADDRESS_WIDTH-1:0] LAST_ADDRESS =
    PIXEL_ADDRESS_WIDTH'(H_ACTIVE * V_ACTIVE - 1);

  logic raw_active;
  logic raw_hsync;
  logic raw_vsync;
  logic raw_frame_start;

  raster_strobe_t                    raw_strobe;
  raster_strobe_t [READ_LATENCY:0]   strobe_dly;
  logic [PIXEL_ADDRESS_WIDTH-1:0]    address_q;
  logic [PIXEL_WIDTH-1:0]            pixel_q;

  display_timing_generator #(
    .H_ACTIVE      (H_ACTIVE),
    .H_FRONT_PORCH (H_FRONT_PORCH),
    .H_SYNC        (H_SYNC),
    .H_BACK_PORCH  (H_BACK_PORCH),
    .V_ACTIVE      (V_ACTIVE),
    .V_FRONT_PORCH (V_FRONT_PORCH),
    .V_SYNC        (V_SYNC),
    .V_BACK_PORCH  (V_BACK_PORCH)
  ) u_timing (
    .clock_in    (clock_in),
    .reset_n     (reset_n_in),
    .enable      (enable_in),
    .active      (raw_active),
    .hsync       (raw_hsync),
    .vsync       (raw_vsync),
    .frame_start (raw_frame_start)
  );

  assign raw_strobe = {raw_active, raw_hsync, raw_vsync, raw_frame_start};

  // Linear address: advances only on active cycles, so horizontal blanking already
  // holds the next line's start and the post-frame wrap leaves 0 through vertical blanking.
  always_ff @(posedge clock_in) begin
    if (!reset_n_in || !enable_in) begin
      address_q <= '0;
    end else if (raw_active) begin
      address_q <= (address_q == LAST_ADDRESS) ? '0 : address_q + PIXEL_ADDRESS_WIDTH'(1);
    end
  end

  // Strobe delay line: stage k holds the strobes of the address presented k+1 clocks ago.
  always_ff @(posedge clock_in) begin
    if (!reset_n_in || !enable_in) begin
      strobe_dly <= '0;
    end else begin
      strobe_dly <= {strobe_dly[READ_LATENCY-1:0], raw_strobe};
    end
  end

  // Capture read data in the cycle it is valid for the address READ_LATENCY clocks back.
  always_ff @(posedge clock_in) begin
    if (!reset_n_in || !enable_in) begin
      pixel_q <= '0;
    end else begin
      pixel_q <= strobe_dly[READ_LATENCY-1].active ? pixel_read_data_in : '0;
    end
  end

  assign pixel_read_address_out = address_q;
  assign display_data_valid_out = strobe_dly[READ_LATENCY].active;
  assign display_hsync_out      = strobe_dly[READ_LATENCY].hsync;
  assign display_vsync_out      = strobe_dly[READ_LATENCY].vsync;
  assign frame_start_out        = strobe_dly[READ_LATENCY].frame_start;
  assign display_pixel_out      = pixel_q;

endmodule

// File: tb/tb_display_scanout.sv
// Self-checking bench for display_scanout: default, mid-size and tiny raster configs.
module tb_display_scanout;

  typedef struct {
    int ha; int hfp; int hs; int hbp;
    int va; int vfp; int vs; int vbp;
    int lat;
  } cfg_t;

  typedef struct {
    int         cyc;
    logic       en;
    int         addr;
    logic       valid;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [3:0] pix;
  } vec_t;

  logic clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  logic reset_n;
  logic enable;

  // default configuration
  logic [17:0] a0;  logic [3:0] d0;  logic hs0, vs0, dv0, fs0;  logic [3:0] px0;
  // mid configuration
  logic [17:0] a1;  logic [3:0] d1;  logic hs1, vs1, dv1, fs1;  logic [3:0] px1;
  // tiny configuration
  logic [17:0] a2;  logic [3:0] d2;  logic hs2, vs2, dv2, fs2;  logic [3:0] px2;

  display_scanout dut_full (
    .clock_in(clock_in), .reset_n_in(reset_n), .enable_in(enable),
    .pixel_read_address_out(a0), .pixel_read_data_in(d0),
    .display_hsync_out(hs0), .display_vsync_out(vs0),
    .display_data_valid_out(dv0), .display_pixel_out(px0), .frame_start_out(fs0));

  display_scanout #(
    .H_ACTIVE(40), .H_FRONT_PORCH(4), .H_SYNC(8), .H_BACK_PORCH(12),
    .V_ACTIVE(25), .V_FRONT_PORCH(2), .V_SYNC(2), .V_BACK_PORCH(3),
    .READ_LATENCY(2)
  ) dut_mid (
    .clock_in(clock_in), .reset_n_in(reset_n), .enable_in(enable),
    .pixel_read_address_out(a1), .pixel_read_data_in(d1),
    .display_hsync_out(hs1), .display_vsync_out(vs1),
    .display_data_valid_out(dv1), .display_pixel_out(px1), .frame_start_out(fs1));

  display_scanout #(
    .H_ACTIVE(4), .H_FRONT_PORCH(1), .H_SYNC(1), .H_BACK_PORCH(1),
    .V_ACTIVE(2), .V_FRONT_PORCH(1), .V_SYNC(1), .V_BACK_PORCH(1),
    .READ_LATENCY(1)
  ) dut_small (
    .clock_in(clock_in), .reset_n_in(reset_n), .enable_in(enable),
    .pixel_read_address_out(a2), .pixel_read_data_in(d2),
    .display_hsync_out(hs2), .display_vsync_out(vs2),
    .display_data_valid_out(dv2), .display_pixel_out(px2), .frame_start_out(fs2));

  // RAM models: return address[3:0] after READ_LATENCY clocks
  logic [3:0] r0a, r0b, r1a, r1b, r2a;
  always @(posedge clock_in) begin
    r0a <= a0[3:0]; r0b <= r0a;
    r1a <= a1[3:0]; r1b <= r1a;
    r2a <= a2[3:0];
  end
  assign d0 = r0b;
  assign d1 = r1b;
  assign d2 = r2a;

  cfg_t cfg[3];
  vec_t vecs[26];

  int n_cmp = 0;
  int n_bad = 0;

  // stats gathered by run_model
  int st_valid, st_hs, st_vs, st_fs, st_first_fs, st_pix_at_fs;
  int st_hs_run_max, st_vs_run_max, st_hs_rise0, st_hs_rise1, st_zrun;
  int hs_run, vs_run, zstate, zcount;
  logic prev_hs;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sample(input int sel, output int aa, output logic [7:0] ao);
    case (sel)
      0:       begin aa = int'(a0); ao = {dv0, hs0, vs0, fs0, px0}; end
      1:       begin aa = int'(a1); ao = {dv1, hs1, vs1, fs1, px1}; end
      default: begin aa = int'(a2); ao = {dv2, hs2, vs2, fs2, px2}; end
    endcase
  endtask

  // Reference address for cycle k counted from a fresh start.
  function automatic int m_addr(cfg_t c, int k);
    int ht, vt, h, v;
    ht = c.ha + c.hfp + c.hs + c.hbp;
    vt = c.va + c.vfp + c.vs + c.vbp;
    h  = k % ht;
    v  = (k / ht) % vt;
    if (v >= c.va) return 0;
    if (h < c.ha) return v * c.ha + h;
    if (v + 1 < c.va) return (v + 1) * c.ha;
    return 0;
  endfunction

  // Reference {valid, hsync, vsync, frame_start, pixel[3:0]} for cycle k.
  function automatic logic [7:0] m_out(cfg_t c, int k);
    int ht, vt, h, v, j, a;
    logic valid, hs, vs, fs;
    logic [3:0] pix;
    j = k - (c.lat + 1);
    if (j < 0) return 8'h00;
    ht = c.ha + c.hfp + c.hs + c.hbp;
    vt = c.va + c.vfp + c.vs + c.vbp;
    h  = j % ht;
    v  = (j / ht) % vt;
    valid = (h < c.ha) && (v < c.va);
    hs    = (h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hs);
    vs    = (v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vs);
    fs    = (h == 0) && (v == 0);
    a     = m_addr(c, j);
    pix   = valid ? a[3:0] : 4'h0;
    return {valid, hs, vs, fs, pix};
  endfunction

  task automatic clear_stats();
    st_valid = 0; st_hs = 0; st_vs = 0; st_fs = 0;
    st_first_fs = -1; st_pix_at_fs = -1;
    st_hs_run_max = 0; st_vs_run_max = 0;
    st_hs_rise0 = -1; st_hs_rise1 = -1; st_zrun = -1;
    hs_run = 0; vs_run = 0; zstate = 0; zcount = 0; prev_hs = 1'b0;
  endtask

  // Compare n cycles starting at cycle k0 (current negedge) against the model; ends at
  // the negedge of cycle k0+n, unsampled, so the caller can drive inputs there.
  task automatic run_model(input int sel, input string name, input int k0, input int n);
    int bad, first_bad, aa, ea, fa, fea, k, last;
    logic [7:0] ao, eo, fo, feo;
    cfg_t c;
    c = cfg[sel];
    last = c.ha * c.va - 1;
    bad = 0; first_bad = -1; fa = 0; fea = 0; fo = 8'h00; feo = 8'h00;
    for (int i = 0; i < n; i++) begin
      k = k0 + i;
      sample(sel, aa, ao);
      ea = m_addr(c, k);
      eo = m_out(c, k);
      if (aa !== ea || ao !== eo) begin
        bad++;
        if (first_bad < 0) begin
          first_bad = k; fa = aa; fea = ea; fo = ao; feo = eo;
        end
      end
      if (ao[7]) st_valid++;
      if (ao[5]) st_vs++;
      if (ao[4]) begin
        st_fs++;
        if (st_first_fs < 0) begin st_first_fs = k; st_pix_at_fs = int'(ao[3:0]); end
      end
      if (ao[6]) begin
        st_hs++;
        hs_run++;
        if (hs_run > st_hs_run_max) st_hs_run_max = hs_run;
        if (!prev_hs) begin
          if (st_hs_rise0 < 0) st_hs_rise0 = k;
          else if (st_hs_rise1 < 0) st_hs_rise1 = k;
        end
      end else begin
        hs_run = 0;
      end
      prev_hs = ao[6];
      if (ao[5]) begin
        vs_run++;
        if (vs_run > st_vs_run_max) st_vs_run_max = vs_run;
      end else begin
        vs_run = 0;
      end
      if (zstate == 1) begin
        if (aa == 0) zcount++;
        else begin st_zrun = zcount; zstate = 2; end
      end else if (zstate == 0 && aa == last) begin
        zstate = 1;
      end
      @(negedge clock_in);
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL model_%s: %0d bad cycles, first k=%0d addr got %0d expected %0d, out got %h expected %h",
               name, bad, first_bad, fa, fea, fo, feo);
    end
  endtask

  initial begin
    int aa, cyc, nz;
    logic [7:0] ao;

    cfg[0] = '{640, 16, 32, 48, 400, 4, 2, 10, 2};
    cfg[1] = '{40, 4, 8, 12, 25, 2, 2, 3, 2};
    cfg[2] = '{4, 1, 1, 1, 2, 1, 1, 1, 1};

    // tiny config: {cycle, enable, addr, valid, hs, vs, fs, pix}
    vecs[0]  = '{0,  1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[1]  = '{1,  1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[2]  = '{2,  1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0};
    vecs[3]  = '{3,  1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1};
    vecs[4]  = '{5,  1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3};
    vecs[5]  = '{6,  1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[6]  = '{7,  1'b1, 4, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    vecs[7]  = '{8,  1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[8]  = '{9,  1'b1, 6, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4};
    vecs[9]  = '{10, 1'b1, 7, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5};
    vecs[10] = '{11, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd6};
    vecs[11] = '{12, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd7};
    vecs[12] = '{13, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[13] = '{14, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    vecs[14] = '{23, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
    vecs[15] = '{28, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0};
    vecs[16] = '{30, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[17] = '{35, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    vecs[18] = '{36, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[19] = '{37, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0};
    vecs[20] = '{38, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1};
    vecs[21] = '{39, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[22] = '{40, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[23] = '{41, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[24] = '{42, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0};
    vecs[25] = '{43, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1};

    reset_n = 1'b0;
    enable  = 1'b1;
    repeat (3) @(negedge clock_in);

    for (int s = 0; s < 3; s++) begin
      sample(s, aa, ao);
      check($sformatf("reset_addr_%0d", s), aa, 0);
      check($sformatf("reset_outputs_%0d", s), int'(ao), 0);
    end

    // Tiny config walk: release reset, current cycle is cycle 0.
    reset_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 26; i++) begin
      while (cyc < vecs[i].cyc) begin
        enable = vecs[i].en;
        @(negedge clock_in);
        cyc++;
      end
      sample(2, aa, ao);
      check($sformatf("small_cycle_%0d", vecs[i].cyc), (aa << 8) | int'(ao),
            (vecs[i].addr << 8) |
            int'({vecs[i].valid, vecs[i].hs, vecs[i].vs, vecs[i].fs, vecs[i].pix}));
    end

    // Default config: two lines of timing from a fresh start.
    enable  = 1'b1;
    reset_n = 1'b0;
    @(negedge clock_in);
    reset_n = 1'b1;
    clear_stats();
    run_model(0, "full_lines", 0, 1475);
    check("full_valid_two_lines", st_valid, 1280);
    check("full_hsync_cycles", st_hs, 64);
    check("full_hsync_width", st_hs_run_max, 32);
    check("full_line_period", st_hs_rise1 - st_hs_rise0, 736);
    check("full_vsync_cycles", st_vs, 0);
    check("full_frame_start_count", st_fs, 1);
    check("full_first_frame_start", st_first_fs, 3);
    check("full_pixel_at_frame_start", st_pix_at_fs, 0);

    // Run on to h=100, v=50 and drop enable for 5 clocks.
    run_model(0, "full_to_v50", 1475, 50 * 736 + 100 - 1475);
    enable = 1'b0;
    nz = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock_in);
      sample(0, aa, ao);
      if (aa != 0 || ao != 8'h00) nz++;
    end
    check("full_enable_low_outputs_zero", nz, 0);
    enable = 1'b1;
    clear_stats();
    run_model(0, "full_restart", 0, 800);
    check("full_restart_frame_start", st_first_fs, 3);
    check("full_restart_fs_count", st_fs, 1);

    // Mid config: one complete frame, then a reset on the last active line.
    reset_n = 1'b0;
    @(negedge clock_in);
    reset_n = 1'b1;
    clear_stats();
    run_model(1, "mid_frame", 0, 2051);
    check("mid_valid_per_frame", st_valid, 1000);
    check("mid_hsync_cycles", st_hs, 256);
    check("mid_hsync_width", st_hs_run_max, 8);
    check("mid_line_period", st_hs_rise1 - st_hs_rise0, 64);
    check("mid_vsync_cycles", st_vs, 128);
    check("mid_vsync_width", st_vs_run_max, 128);
    check("mid_frame_start_count", st_fs, 1);
    check("mid_first_frame_start", st_first_fs, 3);
    // blanking after the last pixel (7*64+24) plus the next frame's address-0 cycle
    check("mid_blank_address_hold", st_zrun, 473);

    run_model(1, "mid_to_v24", 2051, 2 * 2048 + 24 * 64 + 20 - 2051);
    reset_n = 1'b0;
    @(negedge clock_in);
    sample(1, aa, ao);
    check("mid_reset_addr", aa, 0);
    check("mid_reset_outputs", int'(ao), 0);
    reset_n = 1'b1;
    clear_stats();
    run_model(1, "mid_restart", 0, 300);
    check("mid_restart_frame_start", st_first_fs, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/display_scanout.md
Name: display_scanout

Overview:
- Read-side master for the double-buffered display RAM.
- Walks the displayed buffer in raster order, one 4-bit pixel per clock, by driving the buffer's 18-bit pixel read address and consuming its pixel read data.
- Generates hsync, vsync and data-valid timing for the display interface, aligned to the buffer's fixed read latency.
- Holds the read address at 0 throughout vertical blanking, so the buffer block can perform pending buffer switches there.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT_PORCH, 16, clocks after active before hsync
H_SYNC, 32, hsync width in clocks
H_BACK_PORCH, 48, clocks after hsync before active (line total 736)
V_ACTIVE, 400, visible lines per frame
V_FRONT_PORCH, 4, lines after active before vsync
V_SYNC, 2, vsync width in lines
V_BACK_PORCH, 10, lines after vsync before active (frame total 416)
READ_LATENCY, 2, clocks from address presented to matching pixel_read_data_in

Ports:
clock_in  input  1  system clock
reset_n_in  input  1  reset
enable_in  input  1  scanout run; low = idle and restart
pixel_read_address_out  output  18  linear pixel address to display buffers
pixel_read_data_in  input  4  pixel value from display buffers
display_hsync_out  output  1  horizontal sync, active high
display_vsync_out  output  1  vertical sync, active high
display_data_valid_out  output  1  high during active pixels
display_pixel_out  output  4  pixel value, 0 when not valid
frame_start_out  output  1  one-clock pulse with first active pixel of each frame

Behaviour:
- Clocking/reset: one clock, clock_in. Reset is synchronous and active-low on reset_n_in. On reset, all outputs, the h/v counters, the address counter and the delay line go to 0.
- Raster counters:
  - h_count runs 0..H_total-1; v_count runs 0..V_total-1 and increments when h_count wraps.
  - Both wrap to 0 after (H_total-1, V_total-1).
  - H_total = sum of the four H parameters; V_total likewise.
- Active region: h_count < H_ACTIVE and v_count < V_ACTIVE.
- Sync windows:
  - hsync: h_count in [H_ACTIVE+H_FRONT_PORCH, +H_SYNC).
  - vsync: v_count in [V_ACTIVE+V_FRONT_PORCH, +V_SYNC), asserted for whole lines.
- Address generation:
  - A registered counter drives pixel_read_address_out directly.
  - Each active cycle presents the current count and the counter increments.
  - After the last active pixel (H_ACTIVE*V_ACTIVE-1 = 255999), the counter wraps to 0.
  - The address is 0 in every non-active cycle after that point, through the whole vertical blanking.
  - Horizontal blanking holds the next line's start address; no multiplier is used.
- Latency alignment:
  - Address A is presented in cycle n; pixel A is sampled from pixel_read_data_in at the end of cycle n+READ_LATENCY.
  - All display outputs update in cycle n+READ_LATENCY+1.
  - valid/hsync/vsync/frame_start travel through a READ_LATENCY+1 stage shift register, so address-to-output latency is exactly READ_LATENCY+1 clocks.
- display_pixel_out: registered pixel_read_data_in when the delayed valid is high, else 0.
- frame_start_out: high only in the output cycle of pixel address 0 (h=0, v=0).
- enable_in low:
  - Counters, address and delay line are forced to the reset state on the next edge; outputs return to 0 after that edge.
  - Mid-frame deassertion aborts the frame.
  - Re-assertion starts a fresh frame at h=0, v=0, address 0. The first frame_start appears READ_LATENCY+1 clocks after the first enabled edge.
- Reset asserted mid-frame: identical to enable_in low, and takes priority over enable_in.
- Output glitch rule: all outputs are registered; no combinational path from input to output.

Decomposition:
- Package display_timing_pkg holds:
  - default timing constants;
  - derived H_TOTAL/V_TOTAL;
  - PIXEL_ADDRESS_WIDTH=18 and PIXEL_WIDTH=4;
  - FRAME_PIXELS=256000.
- Sub-module display_timing_generator holds the h/v counters and the raw active/hsync/vsync/frame_start strobes.
- The top level adds the address counter, delay line and output register.

Test Plan:
- Full frame, READ_LATENCY=2, bench RAM model returning address[3:0] after 2 clocks:
  - 256000 valid cycles per frame, each pixel equal to its address LSBs;
  - 736 clocks per line, 416 lines per frame.
- Alignment: first valid output exactly 3 clocks after address 0 is presented; display_pixel_out=0 and frame_start_out=1 on that cycle; frame_start_out is low elsewhere.
- Blanking address hold:
  - address 0 on every cycle from the edge after 255999 until the next frame's first active cycle (16*736 + 736-640 clocks);
  - hsync width 32 clocks; vsync width 2*736 clocks.
- enable_in low for 5 clocks at h=100, v=50:
  - outputs 0 from the following cycle;
  - after re-enable, address restarts at 0 and frame_start appears 3 clocks later.
- Reset pulse mid-line at v=399: all outputs 0 the next cycle; scanout restarts at address 0 after release.
- Small config H_ACTIVE=4, V_ACTIVE=2, porches/syncs=1, READ_LATENCY=1: address sequence 0,1,2,3,(hold 4),4,5,6,7, then 0 held through blanking.
